// File: rtl/counter_scheduler_pkg.sv
// Shared state encoding and width helper for the counter scheduler.
package Counter_scheduler_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Index width for n requesters; never narrower than one bit.
   function automatic int IDX_W(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/counter_scheduler_rr.sv
// Combinational round-robin pick: first set request searching upward from ptr+1, wrapping at N.
module counter_scheduler_rr
   import Counter_scheduler_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = IDX_W(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] idx,
   output logic          valid
);

   logic [31:0] cand;

   // Walk from the farthest offset down so the nearest candidate is written last and wins.
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      cand  = '0;
      for (int off = N; off >= 1; off--) begin
         cand = (32'(ptr) + 32'(off)) % 32'(N);
         if (req[cand[IW-1:0]]) begin
            idx   = cand[IW-1:0];
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/counter_scheduler.sv
// Shares one interval counter among N requesters: round-robin grant, count lim cycles, pulse done.
module counter_scheduler
   import Counter_scheduler_pkg::*;
#(
   parameter int N = 4,
   parameter int W = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   req,
   input  logic [N*W-1:0] len,
   input  logic           abort,
   output logic [N-1:0]   grant,
   output logic [N-1:0]   done,
   output logic           busy,
   output logic [W-1:0]   q
);

   localparam int IW = IDX_W(N);

   state_t        state_q;
   logic [IW-1:0] ptr_q;
   logic [IW-1:0] idx_q;
   logic [W-1:0]  lim_q;
   logic [W-1:0]  cnt_q;
   logic [N-1:0]  grant_q;
   logic [N-1:0]  done_q;
   logic [IW-1:0] win_idx;
   logic          win_valid;
   logic [W-1:0]  len_arr [N];

   for (genvar gi = 0; gi < N; gi++) begin : g_len
      assign len_arr[gi] = len[gi*W +: W];
   end

   counter_scheduler_rr #(
      .N  (N),
      .IW (IW)
   ) u_rr (
      .req   (req),
      .ptr   (ptr_q),
      .idx   (win_idx),
      .valid (win_valid)
   );

   function automatic logic [N-1:0] onehot(input logic [IW-1:0] i);
      onehot    = '0;
      onehot[i] = 1'b1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= IW'(N-1);
         idx_q   <= '0;
         lim_q   <= '0;
         cnt_q   <= '0;
         grant_q <= '0;
         done_q  <= '0;
      end else begin
         done_q <= '0;
         unique case (state_q)
            IDLE: begin
               if (win_valid) begin
                  idx_q   <= win_idx;
                  lim_q   <= len_arr[win_idx];
                  grant_q <= onehot(win_idx);
                  state_q <= LOAD;
               end
            end
            LOAD: begin
               cnt_q <= '0;
               if (abort) begin
                  state_q <= IDLE;
                  grant_q <= '0;
                  ptr_q   <= idx_q;
               end else if (lim_q == '0) begin
                  state_q <= DONE;
                  done_q  <= onehot(idx_q);
               end else begin
                  state_q <= RUN;
               end
            end
            RUN: begin
               // Abort beats terminal count; the count stops at lim-1 so it never wraps.
               if (abort) begin
                  state_q <= IDLE;
                  grant_q <= '0;
                  ptr_q   <= idx_q;
               end else if (cnt_q == lim_q - W'(1)) begin
                  state_q <= DONE;
                  done_q  <= onehot(idx_q);
               end else begin
                  cnt_q <= cnt_q + W'(1);
               end
            end
            DONE: begin
               state_q <= IDLE;
               grant_q <= '0;
               ptr_q   <= idx_q;
            end
         endcase
      end
   end

   assign grant = grant_q;
   assign done  = done_q;
   assign busy  = (state_q != IDLE);
   assign q     = cnt_q;

endmodule
